// File: rtl/merge_concat_n_pkg.sv
// Shared definitions for the N-branch concat merger: per-branch field width,
// default 4-branch words-per-position table and the field extractor.
package merge_concat_n_pkg;

  localparam int unsigned BR_FIELD_W = 8;
  localparam int unsigned DEF_NUM_BR = 4;
  localparam logic [DEF_NUM_BR*BR_FIELD_W-1:0] DEF_BR_WORDS = {8'd1, 8'd1, 8'd1, 8'd1};

  // Words-per-position of branch b; the table is packed with branch 0 in the LSBs.
  function automatic logic [BR_FIELD_W-1:0] br_words(input logic [8*BR_FIELD_W-1:0] words,
                                                     input int unsigned b);
    return words[b*BR_FIELD_W +: BR_FIELD_W];
  endfunction

endpackage

// File: rtl/merge_concat_n_if.sv
// Stream bundle of the concat merger: per-branch inputs, merged output, status.
// max_occ exists only when MERGE_OCC_STATS_EN is defined.
interface merge_concat_n_if
  import merge_concat_n_pkg::*;
#(
  parameter int unsigned NUM_BR     = DEF_NUM_BR,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NUM_BR-1:0]            valid_in;
  logic [NUM_BR*DATA_WIDTH-1:0] pxl_in;
  logic                         ready_in;
  logic [DATA_WIDTH-1:0]        pxl_out;
  logic                         valid_out;
  logic                         frame_done;
  logic [NUM_BR-1:0]            overflow;
`ifdef MERGE_OCC_STATS_EN
  logic [NUM_BR*8-1:0]          max_occ;

  modport master (output valid_in, pxl_in, ready_in,
                  input  pxl_out, valid_out, frame_done, overflow, max_occ);
  modport slave  (input  valid_in, pxl_in, ready_in,
                  output pxl_out, valid_out, frame_done, overflow, max_occ);
`else
  modport master (output valid_in, pxl_in, ready_in,
                  input  pxl_out, valid_out, frame_done, overflow);
  modport slave  (input  valid_in, pxl_in, ready_in,
                  output pxl_out, valid_out, frame_done, overflow);
`endif
endinterface

// File: rtl/merge_concat_n_fifo.sv
// Per-branch skew FIFO: power-of-2 depth, combinational head, push and pop
// may coincide at any fill level (a push into a full FIFO is taken if it pops).
module merge_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_WIDTH-1:0]       din,
  output logic [DATA_WIDTH-1:0]       dout,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  do_push, do_pop;

  // Accept/pop decisions and pointer/count update.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != (AW+1)'(FIFO_DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign count = count_q;

endmodule

// File: rtl/merge_concat_n.sv
// N-branch filter-concat merger. One skew FIFO per branch; a sequencer walks
// branch/word/position in concat order and feeds a 1-entry output register.
// Optional per-branch FIFO high-water marks with MERGE_OCC_STATS_EN.
module merge_concat_n
  import merge_concat_n_pkg::*;
#(
  parameter int unsigned                 IMG_SIZE   = 8,
  parameter int unsigned                 NUM_BR     = DEF_NUM_BR,
  parameter logic [NUM_BR*BR_FIELD_W-1:0] BR_WORDS  = DEF_BR_WORDS,
  parameter int unsigned                 FIFO_DEPTH = 16,
  parameter int unsigned                 DATA_WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  merge_concat_n_if.slave bus
);
  localparam int unsigned NPOS  = IMG_SIZE * IMG_SIZE;
  localparam int unsigned SEL_W = (NUM_BR > 1) ? $clog2(NUM_BR) : 1;
  localparam int unsigned POS_W = (NPOS > 1) ? $clog2(NPOS) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [8*BR_FIELD_W-1:0] BR_WORDS_EXT = (8*BR_FIELD_W)'(BR_WORDS);

  logic [NUM_BR-1:0]     f_empty, f_full, f_pop;
  logic [DATA_WIDTH-1:0] f_dout  [NUM_BR];
  logic [CNT_W-1:0]      f_count [NUM_BR];

  for (genvar b = 0; b < NUM_BR; b++) begin : g_br
    merge_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.valid_in[b]),
      .pop   (f_pop[b]),
      .din   (bus.pxl_in[b*DATA_WIDTH +: DATA_WIDTH]),
      .dout  (f_dout[b]),
      .empty (f_empty[b]),
      .full  (f_full[b]),
      .count (f_count[b])
    );
  end

  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [7:0]            wcnt_q, wcnt_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  frame_done_q, frame_done_d;
  logic [NUM_BR-1:0]     overflow_q, overflow_d;
  logic                  load, last_word, last_br, last_pos;

  // Sequencer advance, FIFO pop and output-register load in concat order.
  always_comb begin
    sel_d        = sel_q;
    wcnt_d       = wcnt_q;
    pos_d        = pos_q;
    pxl_out_d    = pxl_out_q;
    valid_out_d  = valid_out_q;
    frame_done_d = frame_done_q;
    f_pop        = '0;
    load      = !f_empty[sel_q] && (!valid_out_q || bus.ready_in);
    last_word = (wcnt_q == br_words(BR_WORDS_EXT, 32'(sel_q)) - 8'd1);
    last_br   = (sel_q == SEL_W'(NUM_BR - 1));
    last_pos  = (pos_q == POS_W'(NPOS - 1));
    if (load) begin
      f_pop[sel_q] = 1'b1;
      pxl_out_d    = f_dout[sel_q];
      valid_out_d  = 1'b1;
      frame_done_d = last_word && last_br && last_pos;
      if (last_word) begin
        wcnt_d = '0;
        if (last_br) begin
          sel_d = '0;
          pos_d = last_pos ? '0 : pos_q + POS_W'(1);
        end else begin
          sel_d = sel_q + SEL_W'(1);
        end
      end else begin
        wcnt_d = wcnt_q + 8'd1;
      end
    end else if (bus.ready_in) begin
      valid_out_d  = 1'b0;
      frame_done_d = 1'b0;
    end
    // A full FIFO only drops the word when it is not popped in the same cycle.
    overflow_d = overflow_q | (bus.valid_in & f_full & ~f_pop);
  end

  // Sequencer, output register and sticky overflow flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q        <= '0;
      wcnt_q       <= '0;
      pos_q        <= '0;
      pxl_out_q    <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= '0;
    end else begin
      sel_q        <= sel_d;
      wcnt_q       <= wcnt_d;
      pos_q        <= pos_d;
      pxl_out_q    <= pxl_out_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.pxl_out    = pxl_out_q;
  assign bus.valid_out  = valid_out_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;

`ifdef MERGE_OCC_STATS_EN
  logic [NUM_BR*8-1:0] max_occ_q, max_occ_d;

  // Per-branch peak FIFO occupancy, saturating at 255.
  always_comb begin
    max_occ_d = max_occ_q;
    for (int unsigned b = 0; b < NUM_BR; b++) begin
      if (32'(f_count[b]) > 32'(max_occ_q[b*8 +: 8]))
        max_occ_d[b*8 +: 8] = (32'(f_count[b]) > 32'd255) ? 8'hFF : 8'(f_count[b]);
    end
  end

  // High-water mark registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) max_occ_q <= '0;
    else        max_occ_q <= max_occ_d;
  end

  assign bus.max_occ = max_occ_q;
`else
  logic unused_count;

  // Occupancy is only consumed by the statistics build.
  always_comb begin
    unused_count = 1'b0;
    for (int unsigned b = 0; b < NUM_BR; b++) unused_count = unused_count ^ (^f_count[b]);
  end
`endif

endmodule
